// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: fetches bytes from a UART data register with a three-state FSM and buffers them for CPU reads.
// Optional `UART_RX_FIFO_DROP_EN` makes a full FIFO keep fetching, drop the byte and set the sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   uart_dat_do,
  output logic          uart_dat_re,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [1:0]    fsm_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POP    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          byte_avail;
  logic          accepts;
  logic          in_pop;
  logic          do_push;
  logic          do_pop;

  assign byte_avail  = (uart_dat_do != 32'hFFFF_FFFF);
  assign in_pop      = (state == POP);
  assign uart_dat_re = in_pop;
  assign fsm_state   = state;

  assign count   = cnt;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign rd_data = empty ? 32'hFFFF_FFFF : {24'd0, mem[rd_ptr]};
  assign do_pop  = rd_en && !empty;

`ifdef UART_RX_FIFO_DROP_EN
  logic drop;

  // A byte fetched into a full FIFO is kept only if a read frees a slot in the same cycle.
  assign accepts = 1'b1;
  assign do_push = in_pop && (!full || rd_en);
  assign drop    = in_pop && full && !rd_en;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;

  // Back-pressure: the byte stays in the UART until there is room.
  assign accepts        = !full || rd_en;
  assign do_push        = in_pop;
  assign overflow       = 1'b0;
  assign unused_ovf_clr = ovf_clr;
`endif

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (byte_avail && accepts) ? POP : IDLE;
      POP:     state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage has no reset; a reset landing on the POP cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wr_ptr] <= uart_dat_do[7:0];
  end

endmodule
